// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Moore main FSM, ALU decoder, condition
// check and the NZCV flags register that gates datapath write enables.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  state_t     state, next_state;
  logic [3:0] flags;
  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic [1:0] flag_w;
  logic       cond_ex, pcs, dp_no_write;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  // State and flags register; flag halves load only when the instruction executes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= next_state;
      if (flag_w[1] && cond_ex) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Next state and per-state controls
  always_comb begin
    next_state = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        next_state = DECODE;
        IRWrite    = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        case (Op)
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        next_state = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB    = 2'b01;
      end
      MEMRD: begin
        next_state = MEMWB;
        AdrSrc     = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR: begin
        next_state = ALUWB;
        alu_op     = 1'b1;
      end
      EXECI: begin
        next_state = ALUWB;
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
    // Reset shows FETCH mux selects with every enable held low
    if (reset) begin
      next_state = FETCH;
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      alu_op     = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b10;
      ALUSrcB    = 2'b10;
      ResultSrc  = 2'b10;
    end
  end

  // Commands that produce no register result (CMP and unsupported encodings)
  always_comb begin
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV: dp_no_write = 1'b0;
      default:                                              dp_no_write = 1'b1;
    endcase
  end

  // ALU decoder
  always_comb begin
    ALUControl = 3'b000;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: ALUControl = 3'b000;
        CMD_SUB: ALUControl = 3'b001;
        CMD_AND: ALUControl = 3'b010;
        CMD_ORR: ALUControl = 3'b011;
        CMD_EOR: ALUControl = 3'b100;
        CMD_MOV: ALUControl = 3'b101;
        CMD_CMP: ALUControl = 3'b001;
        default: ALUControl = 3'b000;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
      if (cmd == CMD_CMP) flag_w = 2'b11;
    end
  end

  // ARM condition evaluation against the stored NZCV
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~(c & ~z);
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // The ALU decoder only runs in EXEC, so the writeback cycle re-derives the
  // no-write property of a data-processing command straight from Funct.
  assign pcs      = branch | (reg_w & (Rd == 4'b1111));
  assign PCWrite  = next_pc | (pcs & cond_ex);
  assign RegWrite = reg_w & cond_ex & ~((Op == 2'b00) & dp_no_write);
  assign MemWrite = mem_w & cond_ex;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control vectors for each
// instruction class, flag register contents, and reset behaviour.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  int passed = 0;
  int total  = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  // {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  logic [13:0] ctl;
  assign ctl = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

  localparam logic [13:0] V_F     = 14'b1_0_0_1_0_10_10_10_000;
  localparam logic [13:0] V_D     = 14'b0_0_0_0_0_10_10_10_000;
  localparam logic [13:0] V_MA    = 14'b0_0_0_0_0_00_01_00_000;
  localparam logic [13:0] V_MR    = 14'b0_0_0_0_1_00_00_00_000;
  localparam logic [13:0] V_MWB   = 14'b0_0_1_0_0_00_00_01_000;
  localparam logic [13:0] V_MW    = 14'b0_1_0_0_1_00_00_00_000;
  localparam logic [13:0] V_ZERO  = 14'b0_0_0_0_0_00_00_00_000;
  localparam logic [13:0] V_ESUB  = 14'b0_0_0_0_0_00_00_00_001;
  localparam logic [13:0] V_EMOV  = 14'b0_0_0_0_0_00_00_00_101;
  localparam logic [13:0] V_IORR  = 14'b0_0_0_0_0_00_01_00_011;
  localparam logic [13:0] V_WB    = 14'b0_0_1_0_0_00_00_00_000;
  localparam logic [13:0] V_WBPC  = 14'b1_0_1_0_0_00_00_00_000;
  localparam logic [13:0] V_BR1   = 14'b1_0_0_0_0_10_01_10_000;
  localparam logic [13:0] V_BR0   = 14'b0_0_0_0_0_10_01_10_000;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
  endtask

  task automatic test_reset();
    set_instr(4'hE, 2'b00, 6'b001000, 4'h1, 4'hF);
    reset = 1'b1;
    @(posedge clk); #2;
    total++;
    if (ctl !== V_D) $display("FAIL reset_outputs ctl=%b want %b", ctl, V_D);
    else passed++;
    total++;
    if (dut.flags !== 4'b0000) $display("FAIL reset_flags flags=%b want 0000", dut.flags);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    total++;
    if (ctl !== V_F) $display("FAIL reset_first_fetch ctl=%b want %b", ctl, V_F);
    else passed++;
    @(posedge clk); #2;
    total++;
    if (ctl !== V_D) $display("FAIL reset_then_decode ctl=%b want %b", ctl, V_D);
    else passed++;
  endtask

  task automatic test_add();
    logic [13:0] v [5];
    do_reset();
    set_instr(4'hE, 2'b00, 6'b001000, 4'h2, 4'h0);
    v = '{V_F, V_D, V_ZERO, V_WB, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL add cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
  endtask

  task automatic test_subs_branch();
    logic [13:0] v [5];
    logic [13:0] b [4];
    do_reset();
    set_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100);
    v = '{V_F, V_D, V_ESUB, V_WB, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL subs cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
    total++;
    if (dut.flags !== 4'b0100) $display("FAIL subs_flags flags=%b want 0100", dut.flags);
    else passed++;
    set_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'b1011);
    b = '{V_F, V_D, V_BR1, V_F};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== b[i]) $display("FAIL beq cyc%0d ctl=%b want %b", i, ctl, b[i]);
      else passed++;
      if (i == 2) begin
        total++;
        if ({ImmSrc, RegSrc} !== 4'b10_01)
          $display("FAIL beq_imm_reg got %b want 1001", {ImmSrc, RegSrc});
        else passed++;
      end
    end
    set_instr(4'h1, 2'b10, 6'b000000, 4'h0, 4'b1011);
    b = '{V_F, V_D, V_BR0, V_F};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== b[i]) $display("FAIL bne cyc%0d ctl=%b want %b", i, ctl, b[i]);
      else passed++;
    end
    total++;
    if (dut.flags !== 4'b0100) $display("FAIL branch_keeps_flags flags=%b want 0100", dut.flags);
    else passed++;
  endtask

  task automatic test_mem();
    logic [13:0] l [6];
    logic [13:0] s [5];
    do_reset();
    set_instr(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0);
    l = '{V_F, V_D, V_MA, V_MR, V_MWB, V_F};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== l[i]) $display("FAIL ldr cyc%0d ctl=%b want %b", i, ctl, l[i]);
      else passed++;
    end
    set_instr(4'hE, 2'b01, 6'b011000, 4'h3, 4'h0);
    s = '{V_F, V_D, V_MA, V_MW, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== s[i]) $display("FAIL str cyc%0d ctl=%b want %b", i, ctl, s[i]);
      else passed++;
    end
  endtask

  task automatic test_cmp_mov();
    logic [13:0] v [5];
    do_reset();
    set_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b1111);
    v = '{V_F, V_D, V_ESUB, V_ZERO, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL cmp cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
    total++;
    if (dut.flags !== 4'b1111) $display("FAIL cmp_flags flags=%b want 1111", dut.flags);
    else passed++;
    set_instr(4'hE, 2'b00, 6'b011010, 4'hF, 4'b0000);
    v = '{V_F, V_D, V_EMOV, V_WBPC, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL mov_pc cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
  endtask

  task automatic test_cond_never();
    logic [13:0] v [5];
    do_reset();
    set_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0101);
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (dut.flags !== 4'b0101) $display("FAIL never_setup_flags flags=%b want 0101", dut.flags);
    else passed++;
    set_instr(4'hF, 2'b00, 6'b001001, 4'h2, 4'b1010);
    v = '{V_F, V_D, V_ZERO, V_ZERO, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL add_never cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
    total++;
    if (dut.flags !== 4'b0101) $display("FAIL never_flags flags=%b want 0101", dut.flags);
    else passed++;
  endtask

  task automatic test_misc_ops();
    logic [13:0] v [5];
    logic [13:0] u [3];
    do_reset();
    set_instr(4'hE, 2'b00, 6'b111000, 4'h4, 4'h0);
    v = '{V_F, V_D, V_IORR, V_WB, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL orr_imm cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
    set_instr(4'hE, 2'b00, 6'b000110, 4'h1, 4'h0);
    v = '{V_F, V_D, V_ZERO, V_ZERO, V_F};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== v[i]) $display("FAIL unsupported_cmd cyc%0d ctl=%b want %b", i, ctl, v[i]);
      else passed++;
    end
    set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0);
    u = '{V_F, V_D, V_F};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #2; end else #1;
      total++;
      if (ctl !== u[i]) $display("FAIL op11 cyc%0d ctl=%b want %b", i, ctl, u[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_instr();
    do_reset();
    set_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b1111);
    repeat (4) @(posedge clk);
    #2;
    set_instr(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (ctl !== V_MR) $display("FAIL midreset_in_memrd ctl=%b want %b", ctl, V_MR);
    else passed++;
    reset = 1'b1; #1;
    total++;
    if (ctl !== V_D) $display("FAIL midreset_outputs ctl=%b want %b", ctl, V_D);
    else passed++;
    total++;
    if (dut.flags !== 4'b1111) $display("FAIL midreset_flags_before_edge flags=%b want 1111", dut.flags);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    total++;
    if (ctl !== V_F) $display("FAIL midreset_fetch ctl=%b want %b", ctl, V_F);
    else passed++;
    total++;
    if (dut.flags !== 4'b0000) $display("FAIL midreset_flags flags=%b want 0000", dut.flags);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_instr(4'hE, 2'b00, 6'b000000, 4'h0, 4'h0);
    test_reset();
    test_add();
    test_subs_branch();
    test_mem();
    test_cmp_mov();
    test_cond_never();
    test_misc_ops();
    test_reset_mid_instr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have exactly the ports below; no parameters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction condition field, Instr[31:28].
REQ-005 Op  input  2  Instr[27:26].
REQ-006 Funct  input  6  Instr[25:20]: I bit = Funct[5], cmd = Funct[4:1], S/L = Funct[0].
REQ-007 Rd  input  4  destination register, Instr[15:12].
REQ-008 ALUFlags  input  4  {N,Z,C,V} from the datapath ALU, current cycle.
REQ-009 PCWrite, MemWrite, RegWrite, IRWrite  output  1 each  datapath write enables.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc  output  2 each  datapath mux selects.
REQ-012 ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV.

Function
REQ-013 A Moore FSM SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-014 Transitions: FETCH->DECODE; DECODE: Op=00 & Funct[5]=0 -> EXECR, Op=00 & Funct[5]=1 -> EXECI, Op=01 -> MEMADR, Op=10 -> BRANCH, Op=11 -> FETCH.
REQ-015 Further transitions: MEMADR -> MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB; EXECR, EXECI -> ALUWB; MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-016 Per-state outputs (unlisted = 0): FETCH IRWrite=1, NextPC=1, ALUSrcA=10, ALUSrcB=10, ResultSrc=10; DECODE ALUSrcA=10, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcB=01.
REQ-017 Per-state outputs, continued: MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegW=1; MEMWR AdrSrc=1, MemW=1; EXECR ALUOp=1; EXECI ALUSrcB=01, ALUOp=1; ALUWB RegW=1; BRANCH ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-018 ImmSrc SHALL equal Op; RegSrc[0] = (Op=10), RegSrc[1] = (Op=01); all three are combinational from the inputs.
REQ-019 With ALUOp=0: ALUControl=000, FlagW=00, NoWrite=0.
REQ-020 With ALUOp=1, cmd mapping: 0100 ADD/000, 0010 SUB/001, 0000 AND/010, 1100 ORR/011, 0001 EOR/100, 1101 MOV/101, 1010 CMP/001 with NoWrite=1; any other cmd gives 000 with NoWrite=1.
REQ-021 With ALUOp=1: FlagW[1] (N,Z) = Funct[0]; FlagW[0] (C,V) = Funct[0] & cmd in {ADD, SUB, CMP}; CMP forces both FlagW bits to 1.
REQ-022 A 4-bit Flags register SHALL load ALUFlags[3:2] when FlagW[1] & CondEx, and ALUFlags[1:0] when FlagW[0] & CondEx, at the clock edge.
REQ-023 CondEx SHALL be combinational from Cond and the stored Flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM; 1110 = always; 1111 = never.
REQ-024 PCS = Branch | (RegW & Rd=1111); PCWrite = NextPC | (PCS & CondEx); RegWrite = RegW & CondEx & ~NoWrite; MemWrite = MemW & CondEx.
REQ-025 A failed condition SHALL NOT alter the state sequence; only write enables and flag updates are suppressed.
REQ-026 Instruction latency in cycles: data-processing 4, LDR 5, STR 4, B 3, Op=11 2.

Reset
REQ-027 Any cycle with reset=1 SHALL load state=FETCH and Flags=0000 at the edge, including mid-instruction.
REQ-028 While reset=1, PCWrite, MemWrite, RegWrite and IRWrite SHALL be 0; mux selects SHALL show their FETCH values.
REQ-029 In the first cycle after reset deasserts, the block SHALL be in FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-030 ADD, Cond=1110, Op=00, Funct=001000 -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
REQ-031 SUBS with ALUFlags=0100 in EXECR, then BEQ -> Flags become 0100; BRANCH raises PCWrite=1; BNE instead gives PCWrite=0 in BRANCH.
REQ-032 LDR with Op=01, Funct[0]=1 -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); STR -> MEMWR with MemWrite=1, then FETCH.
REQ-033 CMP, cmd 1010, S=1 -> RegWrite=0 in ALUWB, all four flags updated; MOV to Rd=15 -> PCWrite=1 in ALUWB.
REQ-034 reset asserted during MEMRD -> next state FETCH, Flags=0000, and no write enable is high during the reset cycle.
REQ-035 Cond=1111 for ADD -> RegWrite=0 and Flags unchanged, with the state sequence identical to REQ-030.
